// File: rtl/wb_stage_if.sv
// wb_stage_if -- request, memory-return and register-file writeback bundle
// for the writeback stage.
//
// Parameters:
//   NSRC  - number of writeback sources (2..16)
//   SEL_W - source-select width, max(1, clog2(NSRC))
//
// Signals:
//   in_valid/in_ready  request handshake
//   in_sel             source select
//   src_data           packed sources, source k at [32k+31:32k]
//   rd_addr/rd_we      destination register and write request
//   ld_fmt/ld_off      load format (RV32I funct3) and byte offset
//   mem_valid/mem_rdata  memory word return
//   wb_valid/wb_we/wb_addr/wb_data/wb_err  register-file writeback
//   wb_count           retired write count
//
// Modports:
//   master - request producer / memory / register file side
//   slave  - the writeback stage itself
interface wb_stage_if #(
    parameter int NSRC  = 4,
    parameter int SEL_W = (NSRC <= 2) ? 1 : $clog2(NSRC)
);
    logic                   in_valid;
    logic                   in_ready;
    logic [SEL_W-1:0]       in_sel;
    logic [NSRC*32-1:0]     src_data;
    logic [4:0]             rd_addr;
    logic                   rd_we;
    logic [2:0]             ld_fmt;
    logic [1:0]             ld_off;
    logic                   mem_valid;
    logic [31:0]            mem_rdata;
    logic                   wb_valid;
    logic                   wb_we;
    logic [4:0]             wb_addr;
    logic [31:0]            wb_data;
    logic                   wb_err;
    logic [31:0]            wb_count;

    modport master (
        output in_valid, in_sel, src_data, rd_addr, rd_we, ld_fmt, ld_off,
               mem_valid, mem_rdata,
        input  in_ready, wb_valid, wb_we, wb_addr, wb_data, wb_err, wb_count
    );

    modport slave (
        input  in_valid, in_sel, src_data, rd_addr, rd_we, ld_fmt, ld_off,
               mem_valid, mem_rdata,
        output in_ready, wb_valid, wb_we, wb_addr, wb_data, wb_err, wb_count
    );
endinterface

// File: rtl/wb_stage.sv
// wb_stage -- register-file writeback stage.
//
// A request selects one of NSRC 32-bit sources. Non-memory sources are
// written back one cycle after the accept. The MEM_IDX source waits in
// WAIT_MEM for the memory word, which is formatted per the captured RV32I
// load format/offset and written back the cycle after mem_valid.
// Illegal selects, illegal formats and misaligned loads produce a
// writeback pulse with wb_err=1, wb_we=0, wb_data=0.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    wb_stage_if.slave (request, memory return, writeback outputs)
module wb_stage #(
    parameter int NSRC    = 4,
    parameter int MEM_IDX = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    wb_stage_if.slave bus
);
    localparam int SEL_W = (NSRC <= 2) ? 1 : $clog2(NSRC);
    localparam logic [31:0] NSRC_U    = 32'(NSRC);
    localparam logic [31:0] MEM_IDX_U = 32'(MEM_IDX);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t        state;
    logic [4:0]    pend_addr;
    logic          pend_we;
    logic [2:0]    pend_fmt;
    logic [1:0]    pend_off;

    logic          valid_q;
    logic          we_q;
    logic          err_q;
    logic [4:0]    addr_q;
    logic [31:0]   data_q;
    logic [31:0]   count_q;

    logic [SEL_W-1:0] sel;
    logic [31:0]      sel_u;
    logic [31:0]      sel_data;
    logic             sel_err;
    logic             sel_we;

    logic [31:0]   shifted;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   ld_data;
    logic          ld_err;
    logic          ld_we;

    assign sel   = bus.in_sel;
    assign sel_u = 32'(sel);

    // Source mux; an out-of-range select falls through to zero data.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (sel_u == 32'(k)) sel_data = bus.src_data[32*k +: 32];
        end
        sel_err = (sel_u >= NSRC_U);
        sel_we  = bus.rd_we && (bus.rd_addr != 5'd0) && !sel_err;
    end

    // Load formatting from the captured format/offset.
    always_comb begin
        shifted = bus.mem_rdata >> {pend_off, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = pend_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        ld_data = '0;
        ld_err  = 1'b0;
        unique case (pend_fmt)
            3'b000: ld_data = {{24{byte_v[7]}}, byte_v};
            3'b100: ld_data = {24'd0, byte_v};
            3'b001: begin
                if (pend_off[0]) ld_err  = 1'b1;
                else             ld_data = {{16{half_v[15]}}, half_v};
            end
            3'b101: begin
                if (pend_off[0]) ld_err  = 1'b1;
                else             ld_data = {16'd0, half_v};
            end
            3'b010: begin
                if (pend_off != 2'd0) ld_err  = 1'b1;
                else                  ld_data = bus.mem_rdata;
            end
            default: ld_err = 1'b1;
        endcase
        ld_we = pend_we && (pend_addr != 5'd0) && !ld_err;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pend_addr <= '0;
            pend_we   <= 1'b0;
            pend_fmt  <= '0;
            pend_off  <= '0;
            valid_q   <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            count_q   <= '0;
        end else begin
            // Strobes are single-cycle; only the two writeback events raise them.
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            unique case (state)
                IDLE: begin
                    // mem_valid is deliberately not looked at here.
                    if (bus.in_valid) begin
                        if (sel_u == MEM_IDX_U) begin
                            pend_addr <= bus.rd_addr;
                            pend_we   <= bus.rd_we;
                            pend_fmt  <= bus.ld_fmt;
                            pend_off  <= bus.ld_off;
                            state     <= WAIT_MEM;
                        end else begin
                            valid_q <= 1'b1;
                            we_q    <= sel_we;
                            err_q   <= sel_err;
                            addr_q  <= bus.rd_addr;
                            data_q  <= sel_data;
                            count_q <= count_q + {31'd0, sel_we};
                        end
                    end
                end
                WAIT_MEM: begin
                    if (bus.mem_valid) begin
                        valid_q <= 1'b1;
                        we_q    <= ld_we;
                        err_q   <= ld_err;
                        addr_q  <= pend_addr;
                        data_q  <= ld_data;
                        count_q <= count_q + {31'd0, ld_we};
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready = (state == IDLE);
    assign bus.wb_valid = valid_q;
    assign bus.wb_we    = we_q;
    assign bus.wb_err   = err_q;
    assign bus.wb_addr  = addr_q;
    assign bus.wb_data  = data_q;
    assign bus.wb_count = count_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage -- directed self-checking bench for wb_stage.
// Instance u_a: NSRC=4, MEM_IDX=3. Instance u_b: NSRC=3, MEM_IDX=2.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_wb_stage;
    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    localparam logic [31:0] S0 = 32'hA0A0_A0A0;
    localparam logic [31:0] S1 = 32'h1234_5678;
    localparam logic [31:0] S2 = 32'h0BAD_F00D;
    localparam logic [31:0] S3 = 32'hDEAD_BEEF;

    wb_stage_if #(.NSRC(4)) a ();
    wb_stage_if #(.NSRC(3)) b ();

    wb_stage #(.NSRC(4), .MEM_IDX(3)) u_a (.clk(clk), .rst_n(rst_n), .bus(a));
    wb_stage #(.NSRC(3), .MEM_IDX(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [1:0] sel, input logic [4:0] rd, input logic we,
                       input logic [2:0] fmt, input logic [1:0] off);
        a.in_valid = 1'b1;
        a.in_sel   = sel;
        a.rd_addr  = rd;
        a.rd_we    = we;
        a.ld_fmt   = fmt;
        a.ld_off   = off;
    endtask

    // Accept a memory request on u_a, return word w on the next cycle.
    task automatic do_load(input logic [4:0] rd, input logic [2:0] fmt,
                           input logic [1:0] off, input logic [31:0] w);
        req(2'd3, rd, 1'b1, fmt, off);
        step();
        a.in_valid  = 1'b0;
        a.mem_valid = 1'b1;
        a.mem_rdata = w;
        step();
        a.mem_valid = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        a.in_valid = 1'b0; a.in_sel = '0; a.src_data = {S3, S2, S1, S0};
        a.rd_addr = '0; a.rd_we = 1'b0; a.ld_fmt = '0; a.ld_off = '0;
        a.mem_valid = 1'b0; a.mem_rdata = '0;
        b.in_valid = 1'b0; b.in_sel = '0; b.src_data = {S2, S1, S0};
        b.rd_addr = '0; b.rd_we = 1'b0; b.ld_fmt = '0; b.ld_off = '0;
        b.mem_valid = 1'b0; b.mem_rdata = '0;

        // Reset state
        #3;
        check("rst_ready", a.in_ready, 1);
        check("rst_valid", a.wb_valid, 0);
        check("rst_data",  a.wb_data, 0);
        check("rst_count", a.wb_count, 0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Single non-memory writeback
        req(2'd1, 5'd5, 1'b1, 3'b000, 2'd0);
        step();
        a.in_valid = 1'b0;
        check("nm_valid", a.wb_valid, 1);
        check("nm_we",    a.wb_we, 1);
        check("nm_addr",  a.wb_addr, 5);
        check("nm_data",  a.wb_data, S1);
        check("nm_err",   a.wb_err, 0);
        check("nm_count", a.wb_count, 1);
        step();
        check("nm_idle_valid", a.wb_valid, 0);
        check("nm_hold_data",  a.wb_data, S1);
        check("nm_hold_addr",  a.wb_addr, 5);

        // LB with 3-cycle memory delay; mem_valid in the accept cycle is ignored
        req(2'd3, 5'd9, 1'b1, 3'b000, 2'd2);
        a.mem_valid = 1'b1;
        a.mem_rdata = 32'h5555_5555;
        step();
        a.in_valid  = 1'b0;
        a.mem_valid = 1'b0;
        check("lb_ready_c1", a.in_ready, 0);
        check("lb_novalid",  a.wb_valid, 0);
        step();
        check("lb_ready_c2", a.in_ready, 0);
        step();
        check("lb_ready_c3", a.in_ready, 0);
        step();
        check("lb_ready_c4", a.in_ready, 0);
        a.mem_valid = 1'b1;
        a.mem_rdata = 32'h0080_0000;
        step();
        a.mem_valid = 1'b0;
        check("lb_valid", a.wb_valid, 1);
        check("lb_data",  a.wb_data, 32'hFFFF_FF80);
        check("lb_err",   a.wb_err, 0);
        check("lb_we",    a.wb_we, 1);
        check("lb_addr",  a.wb_addr, 9);
        check("lb_ready", a.in_ready, 1);
        check("lb_count", a.wb_count, 2);

        // Accept in the same cycle as the load writeback
        req(2'd0, 5'd3, 1'b1, 3'b000, 2'd0);
        step();
        a.in_valid = 1'b0;
        check("ovl_valid", a.wb_valid, 1);
        check("ovl_data",  a.wb_data, S0);
        check("ovl_count", a.wb_count, 3);

        // Misaligned LW
        do_load(5'd7, 3'b010, 2'd1, 32'hCAFE_BABE);
        check("lwm_valid", a.wb_valid, 1);
        check("lwm_we",    a.wb_we, 0);
        check("lwm_err",   a.wb_err, 1);
        check("lwm_data",  a.wb_data, 0);
        check("lwm_addr",  a.wb_addr, 7);
        check("lwm_count", a.wb_count, 3);

        // Other formats
        do_load(5'd10, 3'b001, 2'd2, 32'h8001_1234);
        check("lh_data",  a.wb_data, 32'hFFFF_8001);
        check("lh_err",   a.wb_err, 0);
        do_load(5'd11, 3'b100, 2'd3, 32'h9A00_0000);
        check("lbu_data", a.wb_data, 32'h0000_009A);
        do_load(5'd12, 3'b101, 2'd0, 32'h1234_F00F);
        check("lhu_data", a.wb_data, 32'h0000_F00F);
        do_load(5'd13, 3'b010, 2'd0, 32'h8765_4321);
        check("lw_data",  a.wb_data, 32'h8765_4321);
        check("fmt_count", a.wb_count, 7);
        do_load(5'd14, 3'b001, 2'd1, 32'hFFFF_FFFF);
        check("lhm_err",  a.wb_err, 1);
        check("lhm_data", a.wb_data, 0);
        do_load(5'd15, 3'b110, 2'd0, 32'hFFFF_FFFF);
        check("fmt6_err", a.wb_err, 1);
        check("fmt6_we",  a.wb_we, 0);
        check("bad_count", a.wb_count, 7);
        do_load(5'd0, 3'b010, 2'd0, 32'h1111_1111);
        check("x0ld_we",  a.wb_we, 0);
        check("x0ld_err", a.wb_err, 0);

        // Reset while waiting for memory abandons the load
        req(2'd3, 5'd8, 1'b1, 3'b010, 2'd0);
        step();
        a.in_valid = 1'b0;
        check("rw_wait_ready", a.in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rw_ready_async", a.in_ready, 1);
        check("rw_count_async", a.wb_count, 0);
        check("rw_data_async",  a.wb_data, 0);
        step();
        rst_n = 1'b1;
        a.mem_valid = 1'b1;
        a.mem_rdata = 32'h7777_7777;
        step();
        a.mem_valid = 1'b0;
        check("rw_novalid", a.wb_valid, 0);
        check("rw_ready",   a.in_ready, 1);
        check("rw_count",   a.wb_count, 0);

        // Back-to-back non-memory accepts, x0 on the third
        req(2'd0, 5'd1, 1'b1, 3'b000, 2'd0);
        step();
        check("b2b1_valid", a.wb_valid, 1);
        check("b2b1_data",  a.wb_data, S0);
        req(2'd1, 5'd2, 1'b1, 3'b000, 2'd0);
        step();
        check("b2b2_valid", a.wb_valid, 1);
        check("b2b2_data",  a.wb_data, S1);
        req(2'd2, 5'd0, 1'b1, 3'b000, 2'd0);
        step();
        check("b2b3_valid", a.wb_valid, 1);
        check("b2b3_we",    a.wb_we, 0);
        check("b2b3_err",   a.wb_err, 0);
        check("b2b3_data",  a.wb_data, S2);
        req(2'd0, 5'd4, 1'b1, 3'b000, 2'd0);
        step();
        a.in_valid = 1'b0;
        check("b2b4_valid", a.wb_valid, 1);
        check("b2b4_we",    a.wb_we, 1);
        check("b2b_count",  a.wb_count, 3);
        step();
        check("b2b_end_valid", a.wb_valid, 0);

        // NSRC=3 build: legal select, then out-of-range select
        b.in_valid = 1'b1; b.in_sel = 2'd1; b.rd_addr = 5'd6; b.rd_we = 1'b1;
        step();
        check("n3_legal_data", b.wb_data, S1);
        check("n3_legal_err",  b.wb_err, 0);
        b.in_sel = 2'd3;
        step();
        b.in_valid = 1'b0;
        check("n3_bad_valid", b.wb_valid, 1);
        check("n3_bad_err",   b.wb_err, 1);
        check("n3_bad_data",  b.wb_data, 0);
        check("n3_bad_we",    b.wb_we, 0);
        check("n3_count",     b.wb_count, 1);
        step();
        check("n3_end_err",   b.wb_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter NSRC, default 4, meaning number of writeback sources (legal 2..16).
REQ-002 SHALL have parameter MEM_IDX, default 3, meaning source index whose data comes from the memory port (legal 0..NSRC-1).
REQ-003 SHALL derive localparam SEL_W = max(1, clog2(NSRC)).
REQ-004 SHALL use one clock and an asynchronous, active-low reset; clk is the clock and rst_n is the reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  writeback request present.
REQ-008 in_ready  output  1  stage can accept a request.
REQ-009 in_sel  input  SEL_W  source select.
REQ-010 src_data  input  NSRC*32  packed sources; source k is bits [32k+31:32k].
REQ-011 rd_addr  input  5  destination register.
REQ-012 rd_we  input  1  request writes rd.
REQ-013 ld_fmt  input  3  load format, RV32I funct3 encoding.
REQ-014 ld_off  input  2  load byte offset (address bits [1:0]).
REQ-015 mem_valid  input  1  mem_rdata valid this cycle.
REQ-016 mem_rdata  input  32  raw aligned memory word.
REQ-017 wb_valid  output  1  one-cycle writeback pulse.
REQ-018 wb_we  output  1  register-file write enable, qualified by wb_valid.
REQ-019 wb_addr  output  5  register-file write address.
REQ-020 wb_data  output  32  register-file write data.
REQ-021 wb_err  output  1  one-cycle pulse with wb_valid: illegal select, illegal format or misaligned load.
REQ-022 wb_count  output  32  count of retired writes (wb_valid && wb_we).

Function
REQ-023 SHALL implement FSM with states IDLE and WAIT_MEM; in_ready = (state == IDLE).
REQ-024 Accept: in_valid && in_ready at a rising edge.
REQ-025 Accept with in_sel != MEM_IDX: the next cycle SHALL drive wb_valid=1 and wb_data = selected source (registered); state stays IDLE; latency is 1 cycle.
REQ-026 in_sel >= NSRC SHALL give wb_data=0, wb_we=0 and wb_err=1.
REQ-027 Accept with in_sel == MEM_IDX SHALL capture rd_addr, rd_we, ld_fmt and ld_off, and move to WAIT_MEM.
REQ-028 mem_valid SHALL be ignored in IDLE, including in the accept cycle.
REQ-029 In WAIT_MEM, mem_valid=1 SHALL cause the next cycle to drive wb_valid=1 with formatted data, and SHALL return the FSM to IDLE; with mem_valid=0 the FSM SHALL hold indefinitely.
REQ-030 Load formatting SHALL be:
- LB (000): sign-extend byte[ld_off].
- LBU (100): zero-extend byte[ld_off].
- LH (001): sign-extend half[ld_off[1]].
- LHU (101): zero-extend half[ld_off[1]].
- LW (010): whole word.
REQ-031 LH/LHU with ld_off[0]=1, LW with ld_off!=0, or ld_fmt in {011,110,111} SHALL give wb_we=0, wb_err=1 and wb_data=0.
REQ-032 wb_we SHALL equal captured rd_we && (rd_addr != 0) && !error; x0 writes SHALL be suppressed silently, without wb_err.
REQ-033 wb_valid, wb_we and wb_err SHALL be low in every cycle not named in REQ-025/REQ-029.
REQ-034 wb_addr and wb_data SHALL hold their last value when wb_valid=0.
REQ-035 wb_count SHALL increment by 1 on each cycle with wb_valid && wb_we, and SHALL wrap 0xFFFFFFFF to 0.
REQ-036 The stage SHALL sustain back-to-back non-memory accepts, one per cycle.
REQ-037 A new accept SHALL be possible in the same cycle that wb_valid is high for a completed load.

Reset
REQ-038 rst_n low SHALL immediately force state=IDLE, wb_valid=0, wb_we=0, wb_err=0, wb_addr=0, wb_data=0 and wb_count=0; in_ready SHALL go to 1.
REQ-039 Reset asserted in WAIT_MEM SHALL abandon the pending load; a mem_valid arriving after reset deasserts SHALL be ignored.
REQ-040 Reset deassertion SHALL be synchronised externally; the block SHALL only require that no accept occurs in the deassertion cycle.

Verification
REQ-041 Accept sel=1, src1=0x12345678, rd=5, we=1 -> next cycle: wb_valid=1, wb_we=1, wb_addr=5, wb_data=0x12345678, wb_count=1.
REQ-042 Accept sel=3, fmt=LB, off=2; mem_valid asserted 3 cycles later with mem_rdata=0x00800000 -> in_ready=0 for 4 cycles, then wb_data=0xFFFFFF80 and wb_err=0.
REQ-043 Accept sel=3, fmt=LW, off=1, rd=7 -> on mem_valid: wb_valid=1, wb_we=0, wb_err=1, wb_data=0; wb_count unchanged.
REQ-044 Four back-to-back accepts sel=0,1,2,0 with rd=0 on the third -> four consecutive wb_valid pulses, third with wb_we=0 and wb_err=0; wb_count=3.
REQ-045 NSRC=3 build, accept sel=3 -> wb_err=1, wb_data=0, wb_we=0.
REQ-046 rst_n pulsed low while in WAIT_MEM, then mem_valid=1 -> no wb_valid, in_ready=1, wb_count=0.
